// File: rtl/game_state_manager.sv
// Frame-rate game supervisor: gathers per-pixel collision strobes into sticky
// per-frame flags, commits them on startOfFrame and runs the game-phase FSM.
module game_state_manager #(
  parameter int unsigned INIT_LIVES       = 3,
  parameter int unsigned POINTS_PER_ALIEN = 10,
  parameter int unsigned SCORE_MAX        = 9999,
  parameter int unsigned NUM_ALIENS       = 40,
  parameter int unsigned FREEZE_FRAMES    = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startGame,
  input  logic        alienHit,
  input  logic        playerHitByAlienPulse,
  input  logic [2:0]  playerHitByRocket,
  input  logic        aliensReachedBorder,
  output logic [2:0]  gameState,
  output logic [1:0]  lives,
  output logic [13:0] score,
  output logic [5:0]  kills,
  output logic        freeze,
  output logic        newGamePulse,
  output logic        playerHitPulse,
  output logic        alienKillPulse
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PLAY       = 3'd1,
    ST_HIT_FREEZE = 3'd2,
    ST_GAME_OVER  = 3'd3,
    ST_WIN        = 3'd4
  } state_t;

  state_t      state_r;
  logic        kill_f_r;
  logic        hit_f_r;
  logic        border_f_r;
  logic [7:0]  freeze_cnt_r;
  logic        hit_ev_s;
  logic [5:0]  kills_next_s;
  logic [13:0] score_next_s;

  function automatic logic [13:0] sat_add_score(input logic [13:0] base);
    logic [14:0] sum;
    sum = {1'b0, base} + 15'(POINTS_PER_ALIEN);
    if (sum > 15'(SCORE_MAX)) begin
      sat_add_score = 14'(SCORE_MAX);
    end else begin
      sat_add_score = sum[13:0];
    end
  endfunction

  assign gameState = state_r;

  // Score and kill values that committing this frame's kill flag would produce.
  always_comb begin
    hit_ev_s     = playerHitByAlienPulse | (|playerHitByRocket);
    kills_next_s = kills;
    score_next_s = score;
    if (kill_f_r) begin
      score_next_s = sat_add_score(score);
      if (kills < 6'(NUM_ALIENS)) begin
        kills_next_s = kills + 6'd1;
      end else begin
        kills_next_s = kills;
      end
    end else begin
      score_next_s = score;
    end
  end

  // Game-phase FSM, sticky frame flags and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r        <= ST_IDLE;
      lives          <= 2'(INIT_LIVES);
      score          <= 14'd0;
      kills          <= 6'd0;
      freeze_cnt_r   <= 8'd0;
      kill_f_r       <= 1'b0;
      hit_f_r        <= 1'b0;
      border_f_r     <= 1'b0;
      freeze         <= 1'b1;
      newGamePulse   <= 1'b0;
      playerHitPulse <= 1'b0;
      alienKillPulse <= 1'b0;
    end else begin
      newGamePulse   <= 1'b0;
      playerHitPulse <= 1'b0;
      alienKillPulse <= 1'b0;
      // Flags only live while playing; every other phase discards events.
      if (state_r != ST_PLAY) begin
        kill_f_r   <= 1'b0;
        hit_f_r    <= 1'b0;
        border_f_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (startGame) begin
            state_r      <= ST_PLAY;
            lives        <= 2'(INIT_LIVES);
            score        <= 14'd0;
            kills        <= 6'd0;
            freeze       <= 1'b0;
            newGamePulse <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (startOfFrame) begin
            // Same-cycle events open the next frame's flags rather than being lost.
            kill_f_r   <= alienHit;
            hit_f_r    <= hit_ev_s;
            border_f_r <= aliensReachedBorder;
            if (border_f_r) begin
              state_r <= ST_GAME_OVER;
              lives   <= 2'd0;
              freeze  <= 1'b1;
            end else begin
              score          <= score_next_s;
              kills          <= kills_next_s;
              alienKillPulse <= kill_f_r;
              if (hit_f_r) begin
                playerHitPulse <= 1'b1;
                freeze         <= 1'b1;
                if (lives <= 2'd1) begin
                  state_r <= ST_GAME_OVER;
                  lives   <= 2'd0;
                end else begin
                  state_r      <= ST_HIT_FREEZE;
                  lives        <= lives - 2'd1;
                  freeze_cnt_r <= 8'(FREEZE_FRAMES);
                end
              end else if (kills_next_s == 6'(NUM_ALIENS)) begin
                state_r <= ST_WIN;
                freeze  <= 1'b1;
              end else begin
                state_r <= ST_PLAY;
              end
            end
          end else begin
            kill_f_r   <= kill_f_r | alienHit;
            hit_f_r    <= hit_f_r | hit_ev_s;
            border_f_r <= border_f_r | aliensReachedBorder;
          end
        end
        ST_HIT_FREEZE: begin
          if (startOfFrame) begin
            if (freeze_cnt_r <= 8'd1) begin
              state_r      <= ST_PLAY;
              freeze_cnt_r <= 8'd0;
              freeze       <= 1'b0;
            end else begin
              freeze_cnt_r <= freeze_cnt_r - 8'd1;
            end
          end
        end
        ST_GAME_OVER, ST_WIN: begin
          if (startGame) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          freeze  <= 1'b1;
        end
      endcase
    end
  end

endmodule
